// File: rtl/bht_update_ctrl.sv
// BHT write-port sequencer: pattern-table init walk, then in-order
// draining of queued resolved-branch updates, one write per cycle.
module bht_update_ctrl #(
  parameter int DEPTH        = 4,
  parameter int INIT_ENTRIES = 1024,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1,
  localparam int IW = $clog2(INIT_ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          upd_valid,
  input  logic [15:0]   upd_pc,
  input  logic          upd_taken,
  output logic          upd_ready,
  input  logic          flush,
  input  logic          reinit,
  input  logic          hold,
  output logic          bht_write,
  output logic [15:0]   bht_write_pc,
  output logic          bht_taken,
  output logic          init_write,
  output logic [IW-1:0] init_index,
  output logic          init_active,
  output logic [CW-1:0] count
);

  typedef enum logic {INIT, RUN} state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic        taken;
  } upd_t;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  upd_t            mem_q [DEPTH];
  logic            run, push, pop;

  assign run         = (state_q == RUN);
  assign init_active = !run;
  assign init_write  = !run;
  assign init_index  = idx_q;
  assign count       = cnt_q;

  // Readiness ignores a same-cycle pop so it never depends on hold.
  assign upd_ready = run && (cnt_q != CW'(DEPTH))
                   && !flush && !reinit;
  assign bht_write = run && (cnt_q != '0)
                   && !hold && !flush && !reinit;

  assign push = upd_valid && upd_ready;
  assign pop  = bht_write;

  assign bht_write_pc = mem_q[rd_q].pc;
  assign bht_taken    = mem_q[rd_q].taken;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        if (reinit) begin
          idx_d = '0;
        end else begin
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(INIT_ENTRIES - 1))
            state_d = RUN;
        end
      end
      RUN: begin
        if (reinit) begin
          state_d = INIT;
          idx_d   = '0;
          wr_d    = '0;
          rd_d    = '0;
          cnt_d   = '0;
        end else if (flush) begin
          wr_d  = '0;
          rd_d  = '0;
          cnt_d = '0;
        end else begin
          if (push) wr_d = wr_q + PW'(1);
          if (pop)  rd_d = rd_q + PW'(1);
          cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      idx_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= '{pc: upd_pc, taken: upd_taken};
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed + random bench for bht_update_ctrl with an in-order
// scoreboard of accepted updates and a small INIT/RUN model.
module tb_bht_update_ctrl;

  localparam int NE = 1024;
  localparam int DP = 4;

  logic        clk, reset;
  logic        upd_valid, upd_taken, upd_ready;
  logic [15:0] upd_pc;
  logic        flush, reinit, hold;
  logic        bht_write, bht_taken;
  logic [15:0] bht_write_pc;
  logic        init_write, init_active;
  logic [9:0]  init_index;
  logic [2:0]  count;

  typedef struct {
    logic [15:0] pc;
    logic        tk;
  } ent_t;

  ent_t q[$];
  int   ntot  = 0;
  int   npass = 0;
  bit   m_init = 1'b1;
  int   m_idx  = 0;

  bht_update_ctrl #(.DEPTH(DP), .INIT_ENTRIES(NE)) dut (
    .clk(clk), .reset(reset),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_ready(upd_ready),
    .flush(flush), .reinit(reinit), .hold(hold),
    .bht_write(bht_write), .bht_write_pc(bht_write_pc),
    .bht_taken(bht_taken), .init_write(init_write),
    .init_index(init_index), .init_active(init_active),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc(input logic v, input logic [15:0] pc,
                     input logic tk, input logic h, input logic f,
                     input logic ri, input logic rs);
    logic er, ew;
    ent_t e;
    @(negedge clk);
    upd_valid = v;  upd_pc = pc;  upd_taken = tk;
    hold = h;  flush = f;  reinit = ri;  reset = rs;
    #1;
    if (!rs) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("init_active", 32'(init_active), 32'(m_init));
      chk("init_write", 32'(init_write), 32'(m_init));
      if (m_init)
        chk("init_index", 32'(init_index), 32'(m_idx));
      er = !m_init && (q.size() < DP) && !f && !ri;
      ew = !m_init && (q.size() > 0) && !h && !f && !ri;
      chk("upd_ready", 32'(upd_ready), 32'(er));
      chk("bht_write", 32'(bht_write), 32'(ew));
      if (ew) begin
        e = q.pop_front();
        chk("wr_pc", 32'(bht_write_pc), 32'(e.pc));
        chk("wr_taken", 32'(bht_taken), 32'(e.tk));
      end
      if (er && v) q.push_back('{pc, tk});
    end
    if (rs) begin
      m_init = 1'b1;  m_idx = 0;  q.delete();
    end else if (m_init) begin
      if (ri) m_idx = 0;
      else if (m_idx == NE - 1) begin
        m_init = 1'b0;  m_idx = 0;
      end else m_idx++;
    end else if (ri) begin
      m_init = 1'b1;  m_idx = 0;  q.delete();
    end else if (f) begin
      q.delete();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 16'h0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;  upd_valid = 0;  upd_pc = '0;  upd_taken = 0;
    flush = 0;  reinit = 0;  hold = 0;

    // reset then full init walk
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_init_index", 32'(init_index), 32'd0);
    chk("rst_upd_ready", 32'(upd_ready), 32'd0);
    idle(NE - 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("run_active", 32'(init_active), 32'd0);
    chk("run_ready", 32'(upd_ready), 32'd1);
    chk("run_nowrite", 32'(bht_write), 32'd0);

    // single update latency
    cyc(1, 16'h3042, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("single_wr", 32'(bht_write), 32'd1);
    chk("single_pc", 32'(bht_write_pc), 32'h3042);
    chk("single_tk", 32'(bht_taken), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("single_cnt", 32'(count), 32'd0);
    chk("single_idle", 32'(bht_write), 32'd0);

    // backpressure with hold
    for (int i = 0; i < 4; i++)
      cyc(1, 16'(16'h10 + 2 * i), 1'(i), 1, 0, 0, 0);
    cyc(1, 16'h18, 0, 1, 0, 0, 0);
    chk("full_ready", 32'(upd_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    cyc(1, 16'h18, 0, 0, 0, 0, 0);
    chk("full_drain_pc", 32'(bht_write_pc), 32'h10);
    chk("full_nocredit", 32'(upd_ready), 32'd0);
    cyc(1, 16'h18, 0, 0, 0, 0, 0);
    chk("refill_ready", 32'(upd_ready), 32'd1);
    idle(6);

    // flush with traffic
    for (int i = 0; i < 3; i++)
      cyc(1, 16'(16'h40 + i), 1, 1, 0, 0, 0);
    cyc(1, 16'h99, 1, 1, 1, 0, 0);
    chk("flush_ready", 32'(upd_ready), 32'd0);
    chk("flush_wr", 32'(bht_write), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("flush_cnt", 32'(count), 32'd0);
    idle(2);

    // reinit mid-stream
    cyc(1, 16'h50, 0, 1, 0, 0, 0);
    cyc(1, 16'h52, 1, 1, 0, 0, 0);
    cyc(1, 16'h54, 1, 0, 1, 1, 0);
    chk("reinit_ready", 32'(upd_ready), 32'd0);
    chk("reinit_wr", 32'(bht_write), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("reinit_active", 32'(init_active), 32'd1);
    chk("reinit_idx", 32'(init_index), 32'd0);
    chk("reinit_cnt", 32'(count), 32'd0);
    idle(NE - 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("reinit_run", 32'(init_active), 32'd0);

    // random traffic through the scoreboard
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 31) == 0), 0, 0);
    idle(6);

    // reset at init_index 500
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(500);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("idx500", 32'(init_index), 32'd500);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst500_idx", 32'(init_index), 32'd0);
    idle(NE - 1);
    cyc(1, 16'h7777, 1, 0, 0, 0, 0);
    chk("rst500_run", 32'(init_active), 32'd0);
    idle(3);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
